itch_msg_assembler: RTL and testbench
=====================================

Name: itch_msg_assembler

Overview:
- Producer side of the 320-bit message buffer interface consumed by the order-book parser.
- Accepts a byte-wide framed market-data stream, assembles fixed 40-byte messages MSB-first, and queues them in a small message FIFO.
- Presents the FIFO head on ff_buffer / buffer_not_empty and pops on the parser's ready.
- Drops malformed frames and counts them.

Parameters:
MSG_BYTES, 40, bytes per message; fixed so that MSG_BYTES*8 = 320
FIFO_DEPTH, 2, message FIFO entries; power of 2, >= 2
CNT_W, 16, width of statistics counters

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_last  input  1  final byte of frame
in_ready  output  1  byte accepted when in_valid && in_ready at clk edge
ff_buffer  output  320  FIFO head message; 0 when FIFO empty
buffer_not_empty  output  1  FIFO holds >= 1 message
ready  input  1  parser ready; pop when buffer_not_empty && ready at clk edge
msg_count  output  CNT_W  messages pushed, saturating
err_count  output  CNT_W  malformed frames dropped, saturating

Behaviour:
- Reset (resetn=0 at clk edge): state ASSEMBLE, byte index cnt=0, assembly register 0, FIFO empty (buffer_not_empty=0, ff_buffer=0), msg_count=0, err_count=0. Reset mid-frame discards the partial frame and does not count it as an error.
- Byte placement: accepted byte k (k = cnt) is written to assembly bits [319-8k : 312-8k].
  - Resulting field map: req_type byte 0; order_id bytes 9-12; stock_id bytes 17-20; side byte 21; quantity bytes 22-25; price bytes 26-33.
- in_ready = (state==DISCARD) || (cnt != MSG_BYTES-1) || !fifo_full.
  - Only the final byte is back-pressured.
  - There is no same-cycle pop bypass: when the FIFO is full, the final byte stalls even if a pop occurs that edge.
- ASSEMBLE state, on each accepted byte:
  - cnt < MSG_BYTES-1, in_last=0: store byte, cnt++.
  - cnt < MSG_BYTES-1, in_last=1 (short frame): discard partial, cnt=0, err_count++, stay ASSEMBLE.
  - cnt == MSG_BYTES-1, in_last=1: push {assembly with final byte} to FIFO, cnt=0, msg_count++.
  - cnt == MSG_BYTES-1, in_last=0 (long frame): discard, cnt=0, err_count++, go to DISCARD.
- DISCARD state: accept and drop bytes; on an accepted byte with in_last=1, go to ASSEMBLE with cnt=0. No further err increment for the same frame.
- FIFO:
  - Push-to-output latency is 1 cycle: buffer_not_empty and ff_buffer are valid the cycle after the final-byte edge.
  - ff_buffer is the head entry, held stable while not popped.
  - Simultaneous push and pop is allowed whenever not full before the edge; occupancy is unchanged.
  - Order is strictly FIFO.
  - A pop when empty is ignored.
- Counters saturate at 2^CNT_W-1.
- in_valid=0 cycles (gaps) leave cnt and state unchanged.

Test Plan:
1. Reset, ready=1; send 40-byte frame (byte0=0x53, bytes 9-12=0x00000007, bytes 17-20=0x00000064, in_last on byte 39) -> buffer_not_empty=1 the cycle after the last byte; ff_buffer[319:312]=0x53, [247:216]=7, [183:152]=100; popped at that edge; msg_count=1, err_count=0.
2. ready=0; send 3 good frames back-to-back -> after frame 2, buffer_not_empty=1 and in_ready=0 at frame 3's byte 39 only; raise ready for one edge -> frame 1 popped, frame 3 completes one edge later; heads appear in order 1, 2, 3.
3. Short frame with in_last on byte 10, then a good frame -> err_count=1, nothing pushed for the short frame, good frame bit-exact, msg_count=1.
4. 45-byte frame with in_last on byte 44, then a good frame -> err_count=1, bytes 40-44 dropped with in_ready=1, good frame assembled correctly.
5. Assert resetn=0 after 20 bytes, then send a full frame -> counters 0, buffer_not_empty=0 during reset; new frame assembled from byte 0 with no stale bytes.
6. Good frame with random in_valid gaps -> identical ff_buffer to the gap-free case.

Source files
------------

// File: rtl/itch_msg_assembler.sv
// Byte-stream to 320-bit message assembler with a small message FIFO.
// Malformed (short/long) frames are dropped and counted.
module itch_msg_assembler #(
  parameter int MSG_BYTES  = 40,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [MSG_BYTES*8-1:0] ff_buffer,
  output logic                   buffer_not_empty,
  input  logic                   ready,
  output logic [CNT_W-1:0]       msg_count,
  output logic [CNT_W-1:0]       err_count
);

  localparam int MSG_W = MSG_BYTES * 8;
  localparam int IDX_W = $clog2(MSG_BYTES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

  typedef enum logic {
    ASSEMBLE,
    DISCARD
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [MSG_W-1:0] asm_q, asm_d;

  logic [MSG_W-1:0] mem_q [FIFO_DEPTH];
  logic [MSG_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic [CNT_W-1:0] msg_cnt_q, msg_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic             byte_fire;
  logic             push;
  logic             pop;
  logic             err_inc;
  logic [MSG_W-1:0] push_data;

  assign fifo_full  = (occ_q == FULL_OCC);
  assign fifo_empty = (occ_q == '0);

  // Only the final byte of a message can stall; no pop bypass.
  assign in_ready  = (state_q == DISCARD) ||
                     (cnt_q != LAST_IDX) ||
                     !fifo_full;
  assign byte_fire = in_valid && in_ready;
  assign pop       = !fifo_empty && ready;
  assign push_data = {asm_q[MSG_W-1:8], in_data};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    push    = 1'b0;
    err_inc = 1'b0;
    if (byte_fire) begin
      unique case (state_q)
        ASSEMBLE: begin
          if (cnt_q != LAST_IDX) begin
            if (in_last) begin
              asm_d   = '0;
              cnt_d   = '0;
              err_inc = 1'b1;
            end else begin
              for (int k = 0; k < MSG_BYTES; k++) begin
                if (cnt_q == IDX_W'(k)) begin
                  asm_d[MSG_W-1-8*k -: 8] = in_data;
                end
              end
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            asm_d = '0;
            cnt_d = '0;
            if (in_last) begin
              push = 1'b1;
            end else begin
              err_inc = 1'b1;
              state_d = DISCARD;
            end
          end
        end
        DISCARD: begin
          cnt_d = '0;
          if (in_last) begin
            state_d = ASSEMBLE;
          end
        end
        default: begin
          state_d = ASSEMBLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    msg_cnt_d = msg_cnt_q;
    err_cnt_d = err_cnt_q;
    if (push && (msg_cnt_q != '1)) begin
      msg_cnt_d = msg_cnt_q + 1'b1;
    end
    if (err_inc && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ASSEMBLE;
      cnt_q     <= '0;
      asm_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      msg_cnt_q <= '0;
      err_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      msg_cnt_q <= msg_cnt_d;
      err_cnt_q <= err_cnt_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign buffer_not_empty = !fifo_empty;
  assign ff_buffer        = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign msg_count        = msg_cnt_q;
  assign err_count        = err_cnt_q;

endmodule

// File: tb/tb_itch_msg_assembler.sv
// Directed bench for itch_msg_assembler.
// Inputs change at negedge; outputs are sampled at negedge.
module tb_itch_msg_assembler;

  logic         clk = 1'b0;
  logic         resetn;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [319:0] ff_buffer;
  logic         buffer_not_empty;
  logic         ready;
  logic [15:0]  msg_count;
  logic [15:0]  err_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [319:0] m1, ma, mb, mc, md, me, mf, mg, mh;

  itch_msg_assembler dut (
    .clk              (clk),
    .resetn           (resetn),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_last          (in_last),
    .in_ready         (in_ready),
    .ff_buffer        (ff_buffer),
    .buffer_not_empty (buffer_not_empty),
    .ready            (ready),
    .msg_count        (msg_count),
    .err_count        (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [319:0] got,
                       input logic [319:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [319:0] mk(input int s);
    logic [319:0] m;
    for (int k = 0; k < 40; k++) begin
      m[319-8*k -: 8] = 8'(s * 37 + k * 11 + 1);
    end
    return m;
  endfunction

  function automatic logic [7:0] byte_of(input logic [319:0] m,
                                         input int k);
    return m[319-8*k -: 8];
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic l);
    int n;
    n = 0;
    in_data  = b;
    in_last  = l;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("rdy_timeout", 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [319:0] m,
                            input int nbytes,
                            input bit gaps);
    logic [7:0] b;
    for (int k = 0; k < nbytes; k++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_data  = 8'hFF;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      b = (k < 40) ? byte_of(m, k) : 8'hEE;
      if (k >= 40) check("discard_rdy", in_ready, 1'b1);
      send_byte(b, k == nbytes - 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    resetn   = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    in_last  = 1'b0;
    ready    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_bne", buffer_not_empty, 1'b0);
    check("rst_buf", ff_buffer, '0);
    check("rst_msg", msg_count, 16'd0);
    check("rst_err", err_count, 16'd0);
    check("rst_rdy", in_ready, 1'b1);
    resetn = 1'b1;
    @(negedge clk);

    m1 = mk(1);
    m1[319:312] = 8'h53;
    m1[247:216] = 32'd7;
    m1[183:152] = 32'd100;
    send_frame(m1, 40, 1'b0);
    check("t1_bne", buffer_not_empty, 1'b1);
    check("t1_type", ff_buffer[319:312], 8'h53);
    check("t1_oid", ff_buffer[247:216], 32'd7);
    check("t1_sid", ff_buffer[183:152], 32'd100);
    check("t1_full", ff_buffer, m1);
    @(negedge clk);
    check("t1_popped", buffer_not_empty, 1'b0);
    check("t1_msg", msg_count, 16'd1);
    check("t1_err", err_count, 16'd0);

    ready = 1'b0;
    ma = mk(2);
    mb = mk(3);
    mc = mk(4);
    send_frame(ma, 40, 1'b0);
    check("t2_bne", buffer_not_empty, 1'b1);
    check("t2_headA", ff_buffer, ma);
    send_frame(mb, 40, 1'b0);
    check("t2_holdA", ff_buffer, ma);
    for (int k = 0; k < 39; k++) begin
      send_byte(byte_of(mc, k), 1'b0);
    end
    in_data  = byte_of(mc, 39);
    in_last  = 1'b1;
    in_valid = 1'b1;
    #1;
    check("t2_stall0", in_ready, 1'b0);
    @(negedge clk);
    check("t2_stall1", in_ready, 1'b0);
    check("t2_stableA", ff_buffer, ma);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("t2_headB", ff_buffer, mb);
    check("t2_nobypass", msg_count, 16'd3);
    check("t2_rdy_back", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("t2_msg", msg_count, 16'd4);
    check("t2_stableB", ff_buffer, mb);
    ready = 1'b1;
    @(negedge clk);
    check("t2_headC", ff_buffer, mc);
    @(negedge clk);
    check("t2_empty", buffer_not_empty, 1'b0);

    send_frame(mk(5), 11, 1'b0);
    check("t3_err", err_count, 16'd1);
    check("t3_nopush", buffer_not_empty, 1'b0);
    check("t3_msg0", msg_count, 16'd4);
    md = mk(6);
    send_frame(md, 40, 1'b0);
    check("t3_good", ff_buffer, md);
    check("t3_msg", msg_count, 16'd5);
    @(negedge clk);

    send_frame(mk(7), 45, 1'b0);
    check("t4_err", err_count, 16'd2);
    check("t4_nopush", buffer_not_empty, 1'b0);
    me = mk(8);
    send_frame(me, 40, 1'b0);
    check("t4_good", ff_buffer, me);
    check("t4_msg", msg_count, 16'd6);
    check("t4_err2", err_count, 16'd2);
    @(negedge clk);

    mf = mk(9);
    for (int k = 0; k < 20; k++) begin
      send_byte(byte_of(mf, k), 1'b0);
    end
    resetn = 1'b0;
    @(negedge clk);
    check("t5_bne", buffer_not_empty, 1'b0);
    check("t5_buf", ff_buffer, '0);
    check("t5_msg", msg_count, 16'd0);
    check("t5_err", err_count, 16'd0);
    @(negedge clk);
    resetn = 1'b1;
    ready  = 1'b0;
    mg = mk(10);
    send_frame(mg, 40, 1'b0);
    check("t5_good", ff_buffer, mg);
    check("t5_msg1", msg_count, 16'd1);
    check("t5_err0", err_count, 16'd0);
    ready = 1'b1;
    @(negedge clk);
    check("t5_empty", buffer_not_empty, 1'b0);

    ready = 1'b0;
    mh = mk(11);
    send_frame(mh, 40, 1'b1);
    check("t6_bne", buffer_not_empty, 1'b1);
    check("t6_gaps", ff_buffer, mh);
    check("t6_msg", msg_count, 16'd2);
    ready = 1'b1;
    @(negedge clk);
    check("t6_empty", buffer_not_empty, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
